// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480 raster constants and capture FSM state type
// Shared by vga_capture and its edge detectors.
//   H_*  : horizontal timing in pixel ticks (visible, front porch, sync, back porch)
//   V_*  : vertical timing in lines
//   LEN_MAX : saturation value of the 10-bit line/frame length counters
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int LEN_MAX   = 1023;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } vga_state_t;

endpackage

// File: rtl/vga_edge_det.sv
// rtl/vga_edge_det.sv - pix_tick-qualified falling-edge detector for an active-low sync
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   pix_tick     : pixel strobe; history only updates when high
//   sync_in      : raw sync input
//   fall         : high on the pix_tick where sync_in is 0 and the previous sample was 1
module vga_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic pix_tick,
  input  logic sync_in,
  output logic fall
);

  // History resets high so a sync already low at release is not seen as an edge.
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b1;
    end else if (pix_tick) begin
      sync_q <= sync_in;
    end
  end

  assign fall = pix_tick & sync_q & ~sync_in;

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA timing recovery, lock FSM and pixel capture
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   pix_tick            : pixel strobe; all sampling is qualified by it
//   hsync, vsync        : active-low sync pulses
//   rgb [CD]            : incoming pixel colour
//   x, y [10]           : recovered coordinates of the captured pixel
//   pix_valid           : one-clk strobe for a visible pixel while locked
//   pix_rgb [CD]        : captured colour
//   frame_start         : pix_valid at x=0, y=0
//   locked              : timing lock status
//   err_cnt [8]         : saturating lock-loss counter
module vga_capture
  import vga_pkg::*;
#(
  parameter int CD    = 12,
  parameter int H_VIS = H_VISIBLE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_VIS = V_VISIBLE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_tick,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [CD-1:0] rgb,
  output logic [9:0]    x,
  output logic [9:0]    y,
  output logic          pix_valid,
  output logic [CD-1:0] pix_rgb,
  output logic          frame_start,
  output logic          locked,
  output logic [7:0]    err_cnt
);

  localparam logic [9:0] H_LEN   = 10'(H_VIS + H_FP + H_SW + H_BP);
  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] H_LOAD  = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_VIS_C = 10'(H_VIS);
  localparam logic [9:0] V_LEN   = 10'(V_VIS + V_FP + V_SW + V_BP);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
  localparam logic [9:0] V_LOAD  = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_VIS_C = 10'(V_VIS);
  localparam logic [9:0] LEN_SAT = 10'(LEN_MAX);

  logic       hs_fall, vs_fall;
  logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  logic [9:0] line_cnt, frame_cnt;
  logic       line_ovf, line_bad, frame_bad;
  logic       line_err;
  vga_state_t state;

  vga_edge_det u_hs_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .pix_tick (pix_tick),
    .sync_in  (hsync),
    .fall     (hs_fall)
  );

  vga_edge_det u_vs_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .pix_tick (pix_tick),
    .sync_in  (vsync),
    .fall     (vs_fall)
  );

  // Position of the pixel presented on this tick; a sync fall re-anchors the
  // counter to where that edge sits in the standard raster.
  always_comb begin
    hcnt_nxt = hcnt + 10'd1;
    if (hs_fall) begin
      hcnt_nxt = H_LOAD;
    end else if (hcnt == H_LAST) begin
      hcnt_nxt = '0;
    end

    vcnt_nxt = vcnt;
    if (vs_fall) begin
      vcnt_nxt = V_LOAD;
    end else if (hs_fall) begin
      vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
    end
  end

  // line_cnt holds ticks since the last hsync fall (inclusive of the next one),
  // so at a fall it equals the length of the line just ended.
  assign line_ovf  = pix_tick & ~hs_fall & (line_cnt == LEN_SAT - 10'd1);
  assign line_bad  = (hs_fall & (line_cnt != H_LEN)) | line_ovf;
  assign frame_bad = vs_fall & (frame_cnt != V_LEN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt      <= '0;
      vcnt      <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
    end else if (pix_tick) begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;

      if (hs_fall) begin
        line_cnt <= 10'd1;
      end else if (line_cnt != LEN_SAT) begin
        line_cnt <= line_cnt + 10'd1;
      end

      // An hsync fall on the vsync tick belongs to the new frame.
      if (vs_fall) begin
        frame_cnt <= hs_fall ? 10'd1 : 10'd0;
      end else if (hs_fall && frame_cnt != LEN_SAT) begin
        frame_cnt <= frame_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_SEARCH;
      locked   <= 1'b0;
      line_err <= 1'b0;
      err_cnt  <= '0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (vs_fall) begin
            state    <= ST_VERIFY;
            line_err <= 1'b0;
          end
        end
        ST_VERIFY: begin
          if (vs_fall) begin
            if (!frame_bad && !line_err && !line_bad) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
            end else begin
              state  <= ST_SEARCH;
            end
          end else if (line_bad) begin
            line_err <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (line_bad || frame_bad) begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        default: begin
          state  <= ST_SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      x           <= '0;
      y           <= '0;
      pix_rgb     <= '0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (pix_tick && state == ST_LOCKED &&
          hcnt_nxt < H_VIS_C && vcnt_nxt < V_VIS_C) begin
        pix_valid   <= 1'b1;
        frame_start <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
        x           <= hcnt_nxt;
        y           <= vcnt_nxt;
        pix_rgb     <= rgb;
      end
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - self-checking bench for vga_capture on a reduced raster
module tb_vga_capture;

  // Reduced raster: 24 ticks/line (16 visible), 13 lines/frame (8 visible).
  localparam int HV = 16, HF = 2, HS = 4, HB = 2, HT = HV + HF + HS + HB;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 2, VT = VV + VF + VS + VB;

  localparam int OP_FRAME = 0, OP_LONG = 1, OP_SHORT = 2, OP_OVF = 3;
  localparam int NSTEP = 17;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_tick = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [11:0] rgb = '0;
  logic [9:0]  x, y;
  logic        pix_valid, frame_start, locked;
  logic [11:0] pix_rgb;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  vga_capture #(
    .CD(12), .H_VIS(HV), .H_FP(HF), .H_SW(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SW(VS), .V_BP(VB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_tick    (pix_tick),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .x           (x),
    .y           (y),
    .pix_valid   (pix_valid),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .locked      (locked),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    int op;
    bit exp_locked;
    int exp_err;
  } step_t;

  step_t tbl [NSTEP];

  int checks = 0, failures = 0;
  int gen_h = 0, gen_v = 0;
  bit skip_line = 0, strict = 0;
  int inj_h = -1, inj_v = -1;
  int n_valid = 0, n_fs = 0, n_inj = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pattern(input int h, input int v);
    logic [4:0] hh, vv;
    hh = h[4:0];
    vv = v[4:0];
    return {vv, 2'b00, hh};
  endfunction

  task automatic present();
    hsync = !(gen_h >= HV + HF && gen_h < HV + HF + HS);
    vsync = !(gen_v >= VV + VF && gen_v < VV + VF + VS);
    rgb   = (gen_h == inj_h && gen_v == inj_v) ? 12'hF00 : pattern(gen_h, gen_v);
  endtask

  // One pix_tick cycle followed by one idle cycle.
  task automatic tick();
    logic [9:0] x_hold;
    bit exp_v;
    present();
    pix_tick = 1'b1;
    @(posedge clk); #1;
    pix_tick = 1'b0;
    if (strict) begin
      exp_v = (gen_h < HV) && (gen_v < VV);
      chk("pix_valid", pix_valid, exp_v);
      if (pix_valid) begin
        n_valid++;
        chk("x", x, gen_h);
        chk("y", y, gen_v);
        chk("pix_rgb", pix_rgb, rgb);
        if (pix_rgb == 12'hF00) n_inj++;
      end
      if (frame_start) begin
        n_fs++;
        chk("fs_x", x, 0);
        chk("fs_y", y, 0);
      end
    end
    x_hold = x;
    @(posedge clk); #1;
    if (strict) begin
      chk("idle_valid", pix_valid, 0);
      chk("idle_fs", frame_start, 0);
      chk("hold_x", x, x_hold);
    end
  endtask

  task automatic advance();
    gen_h++;
    if (gen_h == HT) begin
      gen_h = 0;
      gen_v++;
      if (skip_line && gen_v == 3) begin
        gen_v = 4;
        skip_line = 0;
      end
      if (gen_v == VT) gen_v = 0;
    end
  endtask

  task automatic step();
    tick();
    advance();
  endtask

  task automatic run_to(input int h, input int v);
    int guard;
    guard = 0;
    while (!(gen_h == h && gen_v == v) && guard < 2 * HT * VT) begin
      step();
      guard++;
    end
    if (!(gen_h == h && gen_v == v)) begin
      checks++;
      failures++;
      $display("FAIL run_to actual=%0d,%0d expected=%0d,%0d", gen_h, gen_v, h, v);
    end
  endtask

  // Ends just after the tick carrying the vsync falling edge.
  task automatic run_frame();
    run_to(0, VV + VF);
    step();
  endtask

  initial begin
    tbl[0]  = '{OP_FRAME, 1'b0, 0};
    tbl[1]  = '{OP_FRAME, 1'b1, 0};
    tbl[2]  = '{OP_FRAME, 1'b1, 0};
    tbl[3]  = '{OP_LONG,  1'b0, 1};
    tbl[4]  = '{OP_FRAME, 1'b0, 1};
    tbl[5]  = '{OP_FRAME, 1'b1, 1};
    tbl[6]  = '{OP_OVF,   1'b0, 2};
    tbl[7]  = '{OP_FRAME, 1'b0, 2};
    tbl[8]  = '{OP_FRAME, 1'b1, 2};
    tbl[9]  = '{OP_LONG,  1'b0, 3};
    tbl[10] = '{OP_FRAME, 1'b0, 3};
    tbl[11] = '{OP_SHORT, 1'b0, 3};
    tbl[12] = '{OP_FRAME, 1'b0, 3};
    tbl[13] = '{OP_LONG,  1'b0, 3};
    tbl[14] = '{OP_FRAME, 1'b0, 3};
    tbl[15] = '{OP_FRAME, 1'b0, 3};
    tbl[16] = '{OP_FRAME, 1'b1, 3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_rgb", pix_rgb, 0);
    chk("rst_err", err_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("release_locked", locked, 0);

    for (int i = 0; i < NSTEP; i++) begin
      case (tbl[i].op)
        OP_LONG: begin
          run_to(5, 2);
          tick();
          run_to(HV + HF, 2);
          step();
        end
        OP_SHORT: begin
          skip_line = 1;
          run_frame();
        end
        OP_OVF: begin
          run_to(HT - 1, 2);
          repeat (1030) tick();
          advance();
        end
        default: run_frame();
      endcase
      chk($sformatf("step%0d_locked", i), locked, tbl[i].exp_locked);
      chk($sformatf("step%0d_err", i), err_cnt, tbl[i].exp_err);
    end

    // Full locked frame with one injected red pixel.
    inj_h = 10;
    inj_v = 5;
    strict = 1;
    run_frame();
    strict = 0;
    inj_h = -1;
    inj_v = -1;
    chk("frame_valid_count", n_valid, HV * VV);
    chk("frame_start_count", n_fs, 1);
    chk("inject_count", n_inj, 1);
    chk("frame_locked", locked, 1);

    // Asynchronous reset in the middle of a visible line.
    run_to(5, 3);
    present();
    pix_tick = 1'b1;
    @(posedge clk); #1;
    pix_tick = 1'b0;
    chk("pre_reset_valid", pix_valid, 1);
    chk("pre_reset_x", x, 5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", pix_valid, 0);
    chk("async_x", x, 0);
    chk("async_y", y, 0);
    chk("async_rgb", pix_rgb, 0);
    chk("async_locked", locked, 0);
    chk("async_err", err_cnt, 0);
    chk("async_fs", frame_start, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    advance();
    run_frame();
    chk("post_reset_vsync1_locked", locked, 0);
    run_frame();
    chk("post_reset_vsync2_locked", locked, 1);
    chk("post_reset_err", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
